// File: rtl/trena.sv
// Ultrasonic HC-SR04 ranging controller with a 7-bit odd-parity UART character transmitter.
// The sensor and serial FSMs run independently; the transmitter can send a stored BCD digit.
module trena #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int TRIGGER_CYCLES = CLK_HZ / 100_000,
  parameter int CYCLES_PER_CM  = 2941,
  parameter int ECHO_TIMEOUT   = CLK_HZ / 20,
  parameter int BAUD_DIV       = CLK_HZ / 115_200
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        transmissao,
  input  logic        medicao,
  input  logic        echo,
  input  logic [11:0] mem_data,
  input  logic [2:0]  sel,
  output logic        trigger,
  output logic        saida_serial,
  output logic        serial_pronto,
  output logic        sensor_pronto
);

  localparam int TRW = $clog2(TRIGGER_CYCLES + 1);
  localparam int TOW = $clog2(ECHO_TIMEOUT + 1);
  localparam int CMW = $clog2(CYCLES_PER_CM + 1);
  localparam int BDW = $clog2(BAUD_DIV + 1);

  localparam logic [TRW-1:0] TRIG_LOAD = TRW'(TRIGGER_CYCLES - 1);
  localparam logic [TOW-1:0] TO_LAST   = TOW'(ECHO_TIMEOUT - 1);
  localparam logic [CMW-1:0] CM_LAST   = CMW'(CYCLES_PER_CM - 1);
  localparam logic [BDW-1:0] BAUD_LAST = BDW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_TRIGGER, S_WAIT_ECHO, S_MEASURE, S_DONE
  } sensorState_t;

  typedef enum logic [2:0] {
    T_IDLE, T_START, T_DATA, T_PARITY, T_STOP, T_DONE
  } txState_t;

  // Saturating 3-digit BCD increment; 999 is the sticky ceiling.
  function automatic logic [11:0] bcdInc(input logic [11:0] d);
    logic [11:0] r;
    r = d;
    if (d != 12'h999) begin
      if (d[3:0] != 4'd9) begin
        r[3:0] = d[3:0] + 4'd1;
      end else begin
        r[3:0] = 4'd0;
        if (d[7:4] != 4'd9) begin
          r[7:4] = d[7:4] + 4'd1;
        end else begin
          r[7:4]  = 4'd0;
          r[11:8] = d[11:8] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] hexAscii(input logic [3:0] n);
    logic [6:0] r;
    if (n < 4'd10) r = 7'h30 + {3'b000, n};
    else           r = 7'h37 + {3'b000, n};
    return r;
  endfunction

  logic [1:0] r_medSync, r_txSync, r_echoSync;
  logic       r_medPrev, r_txPrev;
  logic       w_medEdge, w_txEdge, w_echo;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_medSync  <= 2'b00;
      r_txSync   <= 2'b00;
      r_echoSync <= 2'b00;
      r_medPrev  <= 1'b0;
      r_txPrev   <= 1'b0;
    end else begin
      r_medSync  <= {r_medSync[0], medicao};
      r_txSync   <= {r_txSync[0], transmissao};
      r_echoSync <= {r_echoSync[0], echo};
      r_medPrev  <= r_medSync[1];
      r_txPrev   <= r_txSync[1];
    end
  end

  assign w_medEdge = r_medSync[1] & ~r_medPrev;
  assign w_txEdge  = r_txSync[1] & ~r_txPrev;
  assign w_echo    = r_echoSync[1];

  sensorState_t   r_sState, w_sNext;
  logic [TRW-1:0] r_trigCnt;
  logic [TOW-1:0] r_toCnt;
  logic [CMW-1:0] r_cmCnt;
  logic [11:0]    r_dist, r_stored;
  logic           r_sensorPronto;
  logic           w_timeout;

  assign w_timeout = (r_toCnt == TO_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_sState <= S_IDLE;
    else        r_sState <= w_sNext;
  end

  always_comb begin
    w_sNext = r_sState;
    case (r_sState)
      S_IDLE, S_DONE: if (w_medEdge) w_sNext = S_TRIGGER;
      S_TRIGGER:      if (r_trigCnt == '0) w_sNext = S_WAIT_ECHO;
      S_WAIT_ECHO: begin
        if (w_echo)         w_sNext = S_MEASURE;
        else if (w_timeout) w_sNext = S_DONE;
      end
      S_MEASURE:      if (!w_echo || w_timeout) w_sNext = S_DONE;
      default:        w_sNext = S_IDLE;
    endcase
  end

  // An echo fall takes priority over a same-cycle timeout so a valid width is never lost.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_trigCnt      <= '0;
      r_toCnt        <= '0;
      r_cmCnt        <= '0;
      r_dist         <= 12'h000;
      r_stored       <= 12'h000;
      r_sensorPronto <= 1'b0;
    end else begin
      case (r_sState)
        S_IDLE, S_DONE: begin
          if (w_medEdge) begin
            r_sensorPronto <= 1'b0;
            r_trigCnt      <= TRIG_LOAD;
          end
        end
        S_TRIGGER: begin
          if (r_trigCnt == '0) r_toCnt <= '0;
          else                 r_trigCnt <= r_trigCnt - 1'b1;
        end
        S_WAIT_ECHO: begin
          if (w_echo) begin
            r_toCnt <= '0;
            r_cmCnt <= '0;
            r_dist  <= 12'h000;
          end else if (w_timeout) begin
            r_stored       <= 12'h999;
            r_sensorPronto <= 1'b1;
          end else begin
            r_toCnt <= r_toCnt + 1'b1;
          end
        end
        S_MEASURE: begin
          if (!w_echo) begin
            r_stored       <= r_dist;
            r_sensorPronto <= 1'b1;
          end else if (w_timeout) begin
            r_stored       <= 12'h999;
            r_sensorPronto <= 1'b1;
          end else begin
            r_toCnt <= r_toCnt + 1'b1;
            if (r_cmCnt == CM_LAST) begin
              r_cmCnt <= '0;
              r_dist  <= bcdInc(r_dist);
            end else begin
              r_cmCnt <= r_cmCnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign trigger       = (r_sState == S_TRIGGER);
  assign sensor_pronto = r_sensorPronto;

  logic [6:0] w_char;

  always_comb begin
    w_char = 7'h23;
    case (sel)
      3'd0: w_char = hexAscii(mem_data[3:0]);
      3'd1: w_char = hexAscii(mem_data[7:4]);
      3'd2: w_char = hexAscii(mem_data[11:8]);
      3'd3: w_char = 7'h30 + {3'b000, r_stored[11:8]};
      3'd4: w_char = 7'h30 + {3'b000, r_stored[7:4]};
      3'd5: w_char = 7'h30 + {3'b000, r_stored[3:0]};
      3'd6: w_char = 7'h2C;
      default: w_char = 7'h23;
    endcase
  end

  txState_t       r_tState, w_tNext;
  logic [BDW-1:0] r_baudCnt;
  logic [2:0]     r_bitIdx;
  logic [6:0]     r_shift;
  logic           r_parity;
  logic           r_serialPronto;
  logic           w_baudTick;
  logic           w_txBit;

  assign w_baudTick = (r_baudCnt == BAUD_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_tState <= T_IDLE;
    else        r_tState <= w_tNext;
  end

  always_comb begin
    w_tNext = r_tState;
    w_txBit = 1'b1;
    case (r_tState)
      T_IDLE, T_DONE: if (w_txEdge) w_tNext = T_START;
      T_START: begin
        w_txBit = 1'b0;
        if (w_baudTick) w_tNext = T_DATA;
      end
      T_DATA: begin
        w_txBit = r_shift[0];
        if (w_baudTick && r_bitIdx == 3'd6) w_tNext = T_PARITY;
      end
      T_PARITY: begin
        w_txBit = r_parity;
        if (w_baudTick) w_tNext = T_STOP;
      end
      T_STOP:  if (w_baudTick) w_tNext = T_DONE;
      default: w_tNext = T_IDLE;
    endcase
  end

  // The character and its odd parity are captured at the start edge so the frame is immune to sel/mem_data changes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_baudCnt      <= '0;
      r_bitIdx       <= 3'd0;
      r_shift        <= 7'h00;
      r_parity       <= 1'b0;
      r_serialPronto <= 1'b0;
    end else begin
      case (r_tState)
        T_IDLE, T_DONE: begin
          if (w_txEdge) begin
            r_serialPronto <= 1'b0;
            r_shift        <= w_char;
            r_parity       <= ~^w_char;
            r_baudCnt      <= '0;
            r_bitIdx       <= 3'd0;
          end
        end
        default: begin
          if (w_baudTick) begin
            r_baudCnt <= '0;
            if (r_tState == T_DATA) begin
              r_shift  <= {1'b0, r_shift[6:1]};
              r_bitIdx <= r_bitIdx + 3'd1;
            end
            if (r_tState == T_STOP) r_serialPronto <= 1'b1;
          end else begin
            r_baudCnt <= r_baudCnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign saida_serial  = w_txBit;
  assign serial_pronto = r_serialPronto;

endmodule

// File: tb/tb_trena.sv
// Directed bench for trena with scaled-down timing constants; each check is an immediate assertion.
module tb_trena;

  localparam int TRIG_CYC = 5;
  localparam int CPC      = 10;
  localparam int TIMEOUT  = 2000;
  localparam int BAUD     = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        transmissao;
  logic        medicao;
  logic        echo;
  logic [11:0] memData;
  logic [2:0]  sel;
  logic        trigger;
  logic        saidaSerial;
  logic        serialPronto;
  logic        sensorPronto;

  int checkCount = 0;
  int failCount  = 0;

  trena #(
    .CLK_HZ(50_000_000),
    .TRIGGER_CYCLES(TRIG_CYC),
    .CYCLES_PER_CM(CPC),
    .ECHO_TIMEOUT(TIMEOUT),
    .BAUD_DIV(BAUD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .transmissao(transmissao),
    .medicao(medicao),
    .echo(echo),
    .mem_data(memData),
    .sel(sel),
    .trigger(trigger),
    .saida_serial(saidaSerial),
    .serial_pronto(serialPronto),
    .sensor_pronto(sensorPronto)
  );

  always #5 clock = ~clock;

  initial begin
    repeat (60000) @(posedge clock);
    $display("[TB] FAIL watchdog: observed no end, expected finish before 60000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic med, input logic tx, input logic [2:0] s, input logic [11:0] m);
    @(negedge clock);
    medicao     = med;
    transmissao = tx;
    sel         = s;
    memData     = m;
  endtask

  // Samples each bit in the middle of its baud period; bits are start, 7 data LSB first, parity, stop.
  task automatic receiveFrame(input string tag, input logic [6:0] expChar, input logic expParity);
    logic [9:0] got;
    logic       prontoBefore;
    logic       prontoAfter;
    bit         seen;
    seen         = 1'b0;
    got          = '0;
    prontoBefore = 1'bx;
    prontoAfter  = 1'bx;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (saidaSerial === 1'b0) seen = 1'b1;
    end
    checkOutput({tag, " start"}, 32'(seen), 32'd1);
    if (seen) begin
      for (int j = 1; j <= 10 * BAUD; j++) begin
        @(negedge clock);
        if (j % BAUD == BAUD / 2) got[j / BAUD] = saidaSerial;
        if (j == 10 * BAUD - 1) prontoBefore = serialPronto;
        if (j == 10 * BAUD) prontoAfter = serialPronto;
      end
      checkOutput({tag, " frame"}, 32'(got), 32'({1'b1, expParity, expChar, 1'b0}));
      checkOutput({tag, " pronto in stop"}, 32'(prontoBefore), 32'd0);
      checkOutput({tag, " pronto at 10 bits"}, 32'(prontoAfter), 32'd1);
    end
  endtask

  task automatic sendChar(input string tag, input logic [2:0] s, input logic [11:0] m,
                          input logic [6:0] expChar, input logic expParity);
    applyStimulus(medicao, 1'b1, s, m);
    receiveFrame(tag, expChar, expParity);
    applyStimulus(medicao, 1'b0, s, m);
    repeat (3) @(negedge clock);
  endtask

  // Starts a measurement and checks the trigger pulse; returns once the trigger has ended.
  task automatic startMeasure(input string tag);
    bit seen;
    int width;
    seen  = 1'b0;
    width = 0;
    applyStimulus(1'b1, transmissao, sel, memData);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (trigger === 1'b1) seen = 1'b1;
    end
    checkOutput({tag, " trigger seen"}, 32'(seen), 32'd1);
    while (trigger === 1'b1 && width < 100) begin
      width++;
      @(negedge clock);
    end
    checkOutput({tag, " trigger width"}, 32'(width), 32'(TRIG_CYC));
    checkOutput({tag, " pronto cleared"}, 32'(sensorPronto), 32'd0);
    applyStimulus(1'b0, transmissao, sel, memData);
  endtask

  task automatic echoMeasure(input string tag, input int echoWidth);
    int delay;
    bit seen;
    startMeasure(tag);
    repeat (20) @(negedge clock);
    echo = 1'b1;
    repeat (echoWidth) @(negedge clock);
    echo  = 1'b0;
    delay = 0;
    seen  = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clock);
      delay++;
      if (sensorPronto === 1'b1) seen = 1'b1;
    end
    checkOutput({tag, " pronto delay"}, 32'(delay), 32'd3);
  endtask

  initial begin
    bit seen;
    reset       = 1'b0;
    transmissao = 1'b0;
    medicao     = 1'b0;
    echo        = 1'b0;
    memData     = 12'h000;
    sel         = 3'd0;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    checkOutput("idle trigger", 32'(trigger), 32'd0);
    checkOutput("idle saida", 32'(saidaSerial), 32'd1);
    checkOutput("idle serial_pronto", 32'(serialPronto), 32'd0);
    checkOutput("idle sensor_pronto", 32'(sensorPronto), 32'd0);

    echoMeasure("short", 5);
    sendChar("short units", 3'd5, 12'h000, 7'h30, 1'b1);
    sendChar("hex nibble0", 3'd0, 12'h123, 7'h33, 1'b1);
    sendChar("hex nibble2", 3'd2, 12'h123, 7'h31, 1'b0);

    echoMeasure("ten", 105);
    sendChar("ten hundreds", 3'd3, 12'h000, 7'h30, 1'b1);
    sendChar("ten tens", 3'd4, 12'h000, 7'h31, 1'b0);
    sendChar("ten units", 3'd5, 12'h000, 7'h30, 1'b1);

    applyStimulus(medicao, 1'b1, 3'd1, 12'hABC);
    fork
      receiveFrame("hexB", 7'h42, 1'b1);
      begin
        repeat (30) @(negedge clock);
        transmissao = 1'b0;
        sel         = 3'd7;
        memData     = 12'h000;
        repeat (4) @(negedge clock);
        transmissao = 1'b1;
      end
    join
    repeat (5) @(negedge clock);
    checkOutput("mid-frame edge ignored pronto", 32'(serialPronto), 32'd1);
    checkOutput("mid-frame edge ignored line", 32'(saidaSerial), 32'd1);
    applyStimulus(medicao, 1'b0, sel, memData);
    repeat (3) @(negedge clock);

    sendChar("comma", 3'd6, 12'hABC, 7'h2C, 1'b0);
    sendChar("hash", 3'd7, 12'hABC, 7'h23, 1'b0);
    sendChar("hex nibble2 A", 3'd2, 12'hABC, 7'h41, 1'b1);

    echoMeasure("twelve", 125);
    sendChar("twelve tens", 3'd4, 12'h000, 7'h31, 1'b0);
    sendChar("twelve units", 3'd5, 12'h000, 7'h32, 1'b0);

    startMeasure("timeout");
    seen = 1'b0;
    for (int i = 0; i < TIMEOUT + 500 && !seen; i++) begin
      @(negedge clock);
      if (sensorPronto === 1'b1) seen = 1'b1;
    end
    checkOutput("timeout pronto", 32'(seen), 32'd1);
    sendChar("timeout hundreds", 3'd3, 12'h000, 7'h39, 1'b1);
    sendChar("timeout tens", 3'd4, 12'h000, 7'h39, 1'b1);
    sendChar("timeout units", 3'd5, 12'h000, 7'h39, 1'b1);

    applyStimulus(1'b1, 1'b0, 3'd0, 12'h000);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (trigger === 1'b1) seen = 1'b1;
    end
    checkOutput("abort trigger seen", 32'(seen), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("abort trigger", 32'(trigger), 32'd0);
    checkOutput("abort sensor_pronto", 32'(sensorPronto), 32'd0);
    checkOutput("abort serial_pronto", 32'(serialPronto), 32'd0);
    checkOutput("abort saida", 32'(saidaSerial), 32'd1);
    medicao = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    sendChar("after reset units", 3'd5, 12'h000, 7'h30, 1'b1);

    $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule

// File: doc/trena.md
Name: trena

Overview:
- Ultrasonic distance-measurement controller for an HC-SR04-style sensor, with a 7-bit UART character transmitter.
- A measurement command produces a trigger pulse. The block then times the sensor's echo pulse and stores the distance as 3 BCD centimetre digits.
- A transmission command sends one ASCII character over the serial line. `sel` chooses the character: a hex nibble of external memory data, a measured digit, or a separator.
- Sits between the sonar top-level FSM and the sensor/UART pins.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency.
- TRIGGER_CYCLES, 500, trigger pulse width (10 us).
- CYCLES_PER_CM, 2941, echo clocks per centimetre (58.82 us/cm).
- ECHO_TIMEOUT, 2_500_000, max wait for echo rise or echo width (50 ms).
- BAUD_DIV, 434, clocks per UART bit (115200 baud).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- transmissao  in  1  start serial transmission (rising edge).
- medicao  in  1  start measurement (rising edge).
- echo  in  1  sensor echo, asynchronous.
- mem_data  in  12  external data; three hex nibbles.
- sel  in  3  character select for transmission.
- trigger  out  1  sensor trigger pulse.
- saida_serial  out  1  UART TX line, idle high.
- serial_pronto  out  1  character sent; level.
- sensor_pronto  out  1  measurement valid; level.

Behaviour:
- Interface: one clock, `clock`. `reset` is asynchronous, active-low.
- Reset values:
  - trigger=0, saida_serial=1, serial_pronto=0, sensor_pronto=0.
  - Stored measurement = BCD 000.
  - Both FSMs go to IDLE.
- Input synchronisation:
  - medicao, transmissao and echo each pass through a 2-FF synchronizer.
  - Commands act on the synchronized rising edge only. Holding a command high does not retrigger.
- Sensor FSM states: IDLE, TRIGGER, WAIT_ECHO, MEASURE, DONE.
  - IDLE/DONE: a medicao edge clears sensor_pronto, loads the trigger counter and goes to TRIGGER.
  - TRIGGER: trigger=1 for exactly TRIGGER_CYCLES clocks, then WAIT_ECHO.
  - WAIT_ECHO: on synchronized echo high, clear the cycle counter and the BCD distance, then go to MEASURE.
  - MEASURE:
    - Count cycles while echo is high. Each CYCLES_PER_CM cycles, increment the 3-digit BCD distance with decimal carry; the remainder is truncated.
    - The distance saturates at 999.
    - On echo fall, store the distance, set sensor_pronto=1 on the next clock, and go to DONE.
  - Timeout: exceeding ECHO_TIMEOUT in WAIT_ECHO or MEASURE stores 999, sets sensor_pronto and goes to DONE.
  - sensor_pronto stays high until the next medicao edge.
  - A medicao edge during TRIGGER, WAIT_ECHO or MEASURE is ignored.
- Character select (sampled at the transmission start edge):
  - sel 0 → mem_data[3:0] as ASCII hex ('0'-'9' = 0x30-0x39, 'A'-'F' = 0x41-0x46).
  - sel 1 → mem_data[7:4] as ASCII hex.
  - sel 2 → mem_data[11:8] as ASCII hex.
  - sel 3 → measured hundreds digit, 0x30+d.
  - sel 4 → measured tens digit, 0x30+d.
  - sel 5 → measured units digit, 0x30+d.
  - sel 6 → ',' (0x2C).
  - sel 7 → '#' (0x23).
  - The 7-bit character is latched, so later changes to sel/mem_data do not affect the frame in flight.
- Serial FSM states: IDLE, START, DATA, PARITY, STOP, DONE.
  - A transmissao edge in IDLE/DONE clears serial_pronto, latches the character and goes to START.
  - Frame format: start bit 0, then 7 data bits LSB first, then odd parity, then 1 stop bit 1.
  - Each bit is held BAUD_DIV clocks; total 10 bits = 4340 clocks.
  - After the stop bit, serial_pronto=1, held until the next transmissao edge.
  - saida_serial=1 whenever not framing.
  - A transmissao edge while framing is ignored.
- Concurrency:
  - The sensor and serial FSMs are fully independent; simultaneous commands both start.
  - Transmitting sel 3-5 during a measurement sends the last stored value.
- Reset mid-operation aborts immediately to reset values.

Test Plan:
- Reset, then idle 100 us → trigger=0, saida_serial=1, both pronto=0.
- medicao pulse 10 us; echo 5 us wide, 50 us after trigger → trigger high exactly 500 cycles; sensor_pronto rises ~2-3 cycles after echo fall; distance 000.
- mem_data=0x123, sel=0, transmissao pulse → frame 0,'3'=0x33 LSB first, parity bit 1 (data has 4 ones), stop 1; serial_pronto after 4340 cycles.
- echo 588.2 us (29410 cycles), then transmissao with sel=3, 4, 5 → characters '0','1','0'.
- mem_data=0xABC, sel=1, transmissao → 'B'=0x42, parity 1; a second transmissao edge mid-frame is ignored.
- No echo after trigger → after 50 ms, sensor_pronto=1 and the digits read '9','9','9'; reset asserted mid-measurement → trigger=0, sensor_pronto=0 at once.
